// File: rtl/sdp_data_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : sdp_data_ram                                                |
// | Purpose  : Single-clock simple dual-port data RAM with per-byte write  |
// |            enables, optional output register, write-first collision   |
// |            forwarding and a hardware clear sweep gated by ready_o.     |
// | Ports    : clk_i, rst_ni      - clock, async active-low reset          |
// |            clr_i              - pulse: start a clear sweep (ready only)|
// |            ready_o            - 1 = array usable, 0 = sweep running    |
// |            wr_en_i/wr_addr_i/wr_data_i/wr_be_i - write port           |
// |            rd_en_i/rd_addr_i  - read request                          |
// |            rd_data_o/rd_valid_o - read result and its one-cycle strobe|
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module sdp_data_ram #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    OUT_REG        = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  output logic                    ready_o,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_be_i,
  input  logic                    rd_en_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_valid_o
);

  localparam int                    c_DEPTH   = 2 ** ADDR_WIDTH;
  localparam int                    c_NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] c_CNT_MAX = '1;

  localparam logic [0:0] c_S_CLEAR = 1'b0;
  localparam logic [0:0] c_S_RUN   = 1'b1;
  localparam logic [0:0] c_S_RESET = (CLEAR_ON_RESET != 0) ? c_S_CLEAR : c_S_RUN;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  w_sweep;

  logic [DATA_WIDTH-1:0] mem_q [c_DEPTH];

  logic                  w_wr_go, w_rd_go, w_fwd;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;
  logic [c_NB-1:0]       w_mem_be;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic                  s1_valid_q;
  logic [DATA_WIDTH-1:0] s1_data_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= c_S_RESET;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_S_CLEAR: if (cnt_q == c_CNT_MAX) state_d = c_S_RUN;
      default:   if (ready_q && clr_i)   state_d = c_S_CLEAR;
    endcase
  end

  // ready is registered from the next state so it rises the cycle after the
  // last sweep write and falls the cycle after an accepted clr.
  always_comb begin
    w_sweep = (state_q == c_S_CLEAR);
    cnt_d   = w_sweep ? (cnt_q + ADDR_WIDTH'(1)) : '0;
    ready_d = (state_d == c_S_RUN);
  end

  assign ready_o = ready_q;

  // -------------------------------------------------------- write path
  assign w_wr_go = ready_q && wr_en_i;
  assign w_rd_go = ready_q && rd_en_i;

  always_comb begin
    if (w_sweep) begin
      w_mem_addr = cnt_q;
      w_mem_data = CLEAR_VALUE;
      w_mem_be   = '1;
    end else begin
      w_mem_addr = wr_addr_i;
      w_mem_data = wr_data_i;
      w_mem_be   = w_wr_go ? wr_be_i : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < c_NB; i++) begin
      if (w_mem_be[i]) mem_q[w_mem_addr][8*i +: 8] <= w_mem_data[8*i +: 8];
    end
  end

  // --------------------------------------------------------- read path
  // Write-first: lanes being written this cycle to the same address return
  // the incoming data, the remaining lanes return the stored bytes.
  assign w_fwd = w_wr_go && (wr_addr_i == rd_addr_i);

  always_comb begin
    w_rd_word = mem_q[rd_addr_i];
    for (int i = 0; i < c_NB; i++) begin
      if (w_fwd && wr_be_i[i]) w_rd_word[8*i +: 8] = wr_data_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= w_rd_go;
      if (w_rd_go) s1_data_q <= w_rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  out_valid_q;
      logic [DATA_WIDTH-1:0] out_data_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= s1_valid_q;
          if (s1_valid_q) out_data_q <= s1_data_q;
        end
      end

      assign rd_data_o  = out_data_q;
      assign rd_valid_o = out_valid_q;
    end else begin : g_no_out_reg
      assign rd_data_o  = s1_data_q;
      assign rd_valid_o = s1_valid_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sdp_data_ram.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_sdp_data_ram                                             |
// | Purpose  : Scoreboard bench for sdp_data_ram. Instance A uses default  |
// |            parameters (8x256, latency 1, clear on reset); instance B   |
// |            is 32-bit, latency 2, ready straight after reset.           |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_sdp_data_ram;

  logic clk;
  logic rst_n;

  // instance A
  logic       clr_a, ready_a, wr_en_a, rd_en_a, rd_valid_a;
  logic [7:0] wr_addr_a, rd_addr_a, wr_data_a, rd_data_a;
  logic [0:0] wr_be_a;
  // instance B
  logic        clr_b, ready_b, wr_en_b, rd_en_b, rd_valid_b;
  logic [7:0]  wr_addr_b, rd_addr_b;
  logic [31:0] wr_data_b, rd_data_b;
  logic [3:0]  wr_be_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] qa_d[$];
  int          qa_c[$];
  logic [31:0] qb_d[$];
  int          qb_c[$];
  logic [31:0] last_a;

  sdp_data_ram u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_a), .ready_o(ready_a),
    .wr_en_i(wr_en_a), .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a), .wr_be_i(wr_be_a),
    .rd_en_i(rd_en_a), .rd_addr_i(rd_addr_a), .rd_data_o(rd_data_a), .rd_valid_o(rd_valid_a)
  );

  sdp_data_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .OUT_REG(1), .CLEAR_ON_RESET(0)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr_b), .ready_o(ready_b),
    .wr_en_i(wr_en_b), .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b), .wr_be_i(wr_be_b),
    .rd_en_i(rd_en_b), .rd_addr_i(rd_addr_b), .rd_data_o(rd_data_b), .rd_valid_o(rd_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard: every issued read pushes its expected word and the cycle at
  // which rd_valid must be seen; unrequested valids find the queue empty.
  always @(negedge clk) begin
    logic [31:0] ed;
    int          ec;
    if (!rst_n) last_a = '0;
    if (rd_valid_a) begin
      if (qa_d.size() == 0) check("a_spurious_valid", 32'(rd_valid_a), 32'd0);
      else begin
        ed = qa_d.pop_front();
        ec = qa_c.pop_front();
        check("a_rd_data", 32'(rd_data_a), ed);
        check("a_rd_cycle", 32'(cyc), 32'(ec));
      end
      last_a = 32'(rd_data_a);
    end else begin
      check("a_rd_hold", 32'(rd_data_a), last_a);
    end
    if (rd_valid_b) begin
      if (qb_d.size() == 0) check("b_spurious_valid", 32'(rd_valid_b), 32'd0);
      else begin
        ed = qb_d.pop_front();
        ec = qb_c.pop_front();
        check("b_rd_data", rd_data_b, ed);
        check("b_rd_cycle", 32'(cyc), 32'(ec));
      end
    end
  end

  task automatic idle();
    clr_a = 1'b0; wr_en_a = 1'b0; rd_en_a = 1'b0;
    clr_b = 1'b0; wr_en_b = 1'b0; rd_en_b = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic wa(input logic [7:0] addr, input logic [7:0] data, input logic be);
    wr_en_a = 1'b1; wr_addr_a = addr; wr_data_a = data; wr_be_a = be;
  endtask

  task automatic ra(input logic [7:0] addr, input logic [7:0] exp);
    rd_en_a = 1'b1; rd_addr_a = addr;
    qa_d.push_back(32'(exp));
    qa_c.push_back(cyc + 1);
  endtask

  task automatic wb(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] be);
    wr_en_b = 1'b1; wr_addr_b = addr; wr_data_b = data; wr_be_b = be;
  endtask

  task automatic rb(input logic [7:0] addr, input logic [31:0] exp);
    rd_en_b = 1'b1; rd_addr_b = addr;
    qb_d.push_back(exp);
    qb_c.push_back(cyc + 2);
  endtask

  // Counts rising edges until ready_a goes high; also captures ready_b
  // right after the first edge. Ends aligned to a falling edge.
  task automatic count_low(output int n, output logic rb_first);
    n = 0;
    rb_first = 1'b0;
    while (!ready_a && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) rb_first = ready_b;
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic rbf;
    rst_n = 1'b0;
    wr_addr_a = '0; rd_addr_a = '0; wr_data_a = '0; wr_be_a = '0;
    wr_addr_b = '0; rd_addr_b = '0; wr_data_b = '0; wr_be_b = '0;
    last_a = '0;
    idle();
    repeat (3) @(negedge clk);
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd0);
    check("rst_valid_a", 32'(rd_valid_a), 32'd0);
    check("rst_data_b", rd_data_b, 32'd0);

    rst_n = 1'b1;
    count_low(n, rbf);
    check("por_sweep_len_a", 32'(n), 32'd256);
    check("por_ready_first_b", 32'(rbf), 32'd1);

    // A: cleared contents, latency 1
    ra(8'd0, 8'h00);   tick();
    ra(8'd128, 8'h00); tick();
    ra(8'd255, 8'h00); tick();
    // A: collisions and write-then-read
    wa(8'd5, 8'h3C, 1'b1); tick();
    wa(8'd5, 8'hA5, 1'b1); ra(8'd5, 8'hA5); tick();
    wa(8'd5, 8'h3C, 1'b1); tick();
    wa(8'd5, 8'hA5, 1'b0); ra(8'd5, 8'h3C); tick();
    ra(8'd5, 8'h3C); tick();
    wa(8'd6, 8'h5D, 1'b1); tick();
    ra(8'd6, 8'h5D); tick();
    tick();

    // B: byte enables, pipelined reads, partial-lane collision
    wb(8'h10, 32'hAABBCCDD, 4'b1111); tick();
    wb(8'h10, 32'h11223344, 4'b0101); tick();
    rb(8'h10, 32'hAA22CC44); tick();
    for (int i = 1; i <= 4; i++) begin
      wb(8'(i), 32'h11 * i, 4'b1111); tick();
    end
    for (int i = 1; i <= 4; i++) begin
      rb(8'(i), 32'h11 * i); tick();
    end
    wb(8'h20, 32'h01020304, 4'b1111); tick();
    wb(8'h20, 32'hA0B0C0D0, 4'b1010); rb(8'h20, 32'hA002C004); tick();
    repeat (3) tick();

    // A: clear sweep with accesses attempted while not ready
    wa(8'd7, 8'hFF, 1'b1); tick();
    ra(8'd7, 8'hFF); tick();
    clr_a = 1'b1; wa(8'd8, 8'h5A, 1'b1); ra(8'd7, 8'hFF); tick();
    check("clr_ready_drop_a", 32'(ready_a), 32'd0);
    wa(8'd9, 8'h77, 1'b1);
    rd_en_a = 1'b1; rd_addr_a = 8'd3;
    count_low(n, rbf);
    idle();
    check("clr_sweep_len_a", 32'(n), 32'd256);
    ra(8'd7, 8'h00); tick();
    ra(8'd8, 8'h00); tick();
    ra(8'd9, 8'h00); tick();
    tick();

    // Reset at sweep count 100 while B has reads in flight
    clr_a = 1'b1; tick();
    repeat (98) tick();
    rb(8'd1, 32'h11); tick();
    rb(8'd2, 32'h22);
    @(posedge clk);
    #1;
    check("pre_rst_valid_b", 32'(rd_valid_b), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_ready_a", 32'(ready_a), 32'd0);
    check("async_ready_b", 32'(ready_b), 32'd0);
    check("async_valid_b", 32'(rd_valid_b), 32'd0);
    check("async_data_b", rd_data_b, 32'd0);
    qb_d.delete();
    qb_c.delete();
    tick();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_low(n, rbf);
    check("rst_sweep_len_a", 32'(n), 32'd256);
    check("rst_ready_first_b", 32'(rbf), 32'd1);
    ra(8'd5, 8'h00); tick();
    rb(8'd3, 32'h33); tick();
    repeat (4) tick();

    check("pending_a", 32'(qa_d.size()), 32'd0);
    check("pending_b", 32'(qb_d.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sdp_data_ram.md
Name: sdp_data_ram

Overview:
- Parametrised single-clock simple dual-port data RAM: one write port, one read port.
- Successor to the fixed 256x8 dual-clock data memory; width and depth are generalised.
- Adds per-byte write enables, an optional output pipeline register, and write-first collision forwarding.
- Adds a hardware clear sequencer that zeroes the array after reset or on request; the CPU data bus sits on it and waits for ready.

Parameters:
- DATA_WIDTH, 8: data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8: address width; DEPTH = 2**ADDR_WIDTH words.
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- CLEAR_ON_RESET, 1: 1 = run the clear sweep after reset deassertion; 0 = ready directly.
- CLEAR_VALUE, 0: word value written by the clear sweep.

Ports:
- clk, input, 1: single clock; everything is rising-edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clr, input, 1: one-cycle pulse; starts a clear sweep when ready=1.
- ready, output, 1: 1 = array usable; 0 = clear in progress.
- wr_en, input, 1: write strobe.
- wr_addr, input, ADDR_WIDTH: write address.
- wr_data, input, DATA_WIDTH: write data.
- wr_be, input, DATA_WIDTH/8: byte enables; bit i covers wr_data[8i+7:8i].
- rd_en, input, 1: read strobe.
- rd_addr, input, ADDR_WIDTH: read address.
- rd_data, output, DATA_WIDTH: read data.
- rd_valid, output, 1: 1 for exactly one cycle when rd_data carries the result of a read.

Behaviour:
- Reset (rst_n=0, async): rd_data=0, rd_valid=0, ready=0, sweep counter=0, pipeline valids=0. Array contents are not reset.
- FSM states: CLEAR and RUN.
  - Reset state: CLEAR if CLEAR_ON_RESET=1, else RUN. When RUN is entered, ready=1 from the first clock after deassertion.
  - CLEAR: each cycle writes CLEAR_VALUE to address cnt, all bytes, then cnt++. At cnt=DEPTH-1 the write completes and the FSM goes to RUN; ready=1 on the next cycle.
  - Sweep duration: exactly DEPTH cycles.
- Port gating while ready=0: wr_en and rd_en are ignored, no rd_valid is issued, and clr is ignored.
- RUN, clr=1: enter CLEAR with cnt=0; ready=0 on the next cycle.
  - If wr_en/rd_en are asserted in the same cycle as clr, the write is performed and the read is issued.
  - The sweep then overwrites the write.
- Write, RUN: when wr_en=1, each byte lane with wr_be[i]=1 updates mem[wr_addr] on the clock edge. wr_be=0 writes nothing.
- Read, RUN, OUT_REG=0: rd_en=1 at edge N gives rd_data=mem[rd_addr] and rd_valid=1 after edge N.
- Read, OUT_REG=1: the result appears one cycle later (after edge N+1). Back-to-back reads are fully pipelined, one per cycle.
- rd_data holds its last value when rd_valid=0.
- Collision (wr_en and rd_en in the same cycle with wr_addr==rd_addr): write-first.
  - Enabled lanes return the new wr_data.
  - Disabled lanes return the old contents.
- Write at cycle N followed by a read of the same address at N+1 returns the written data.
- Reset mid-sweep or mid-read: outputs return to reset values immediately. After deassertion the sweep restarts from 0 (if CLEAR_ON_RESET=1). In-flight reads are dropped.
- Address wrap: addresses are taken modulo DEPTH (natural truncation). No out-of-range condition exists.

Test Plan:
- Default params, release rst_n -> ready=0 for 256 cycles then 1; reads of addresses 0, 128 and 255 return 0x00 with rd_valid one cycle after rd_en.
- DATA_WIDTH=32: write 0xAABBCCDD to 0x10 with wr_be=1111, then write 0x11223344 with wr_be=0101 -> read returns 0xAA22CC44.
- Collision: mem[5]=0x3C, then wr_en/rd_en to 5 in the same cycle with wr_data=0xA5, wr_be=1 -> rd_data=0xA5. Repeat with wr_be=0 -> rd_data=0x3C.
- OUT_REG=1: rd_en on 4 consecutive cycles to addresses 1..4 (pre-written 0x11..0x44) -> rd_valid high 4 consecutive cycles starting 2 cycles after the first rd_en; data in order.
- Pulse clr after writing 0xFF to address 7 -> ready low for exactly 256 cycles and rd_en ignored meanwhile; afterwards a read of 7 returns 0x00.
- Assert rst_n=0 at sweep count 100 -> ready and rd_valid drop asynchronously; after release the full 256-cycle sweep repeats.
- CLEAR_ON_RESET=0 -> ready=1 on the first clock after reset release.
